// File: rtl/decode_byte_queue_pkg.sv
// Shared definitions for the fetch-to-decode byte queue.
// Byte 0 of any line or window sits at the most significant byte.
package decode_byte_queue_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/decode_byte_queue_if.sv
// Fetch push port and decode window port of the byte queue.
// master = fetch/decode side, slave = the queue itself.
interface decode_byte_queue_if #(
    parameter int IADDRW      = 32,
    parameter int FETCH_BYTES = 16,
    parameter int WIN_BYTES   = 16
);

    logic                        f_valid;
    logic                        f_ready;
    logic [8*FETCH_BYTES-1:0]    f_bytes;
    logic [$clog2(FETCH_BYTES):0] f_nbytes;
    logic [8*WIN_BYTES-1:0]      w_bytes;
    logic [$clog2(WIN_BYTES):0]  w_valid_bytes;
    logic [IADDRW-1:0]           w_pc;
    logic                        d_consume;
    logic [$clog2(WIN_BYTES):0]  d_bytes_read;

    modport master (
        output f_valid, f_bytes, f_nbytes, d_consume, d_bytes_read,
        input  f_ready, w_bytes, w_valid_bytes, w_pc
    );

    modport slave (
        input  f_valid, f_bytes, f_nbytes, d_consume, d_bytes_read,
        output f_ready, w_bytes, w_valid_bytes, w_pc
    );

endinterface

// File: rtl/decode_byte_queue_rotator.sv
// Barrel-rotates the byte store so the head lands at window byte 0,
// then zeroes every window byte past the valid count.
module byte_rotator
    import decode_byte_queue_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int WIN_BYTES = 16,
    localparam int PW       = $clog2(DEPTH),
    localparam int WNW      = $clog2(WIN_BYTES) + 1
) (
    input  byte_t                         data_i [DEPTH],
    input  logic [PW-1:0]                 head_i,
    input  logic [WNW-1:0]                valid_i,
    output logic [BYTE_W*WIN_BYTES-1:0]   win_o
);

    byte_t cur [DEPTH];
    byte_t nxt [DEPTH];

    // One rotate-left stage per head bit, by 2^stage bytes.
    always_comb begin
        cur = data_i;
        nxt = data_i;
        for (int s = 0; s < PW; s++) begin
            for (int j = 0; j < DEPTH; j++) begin
                nxt[j] = head_i[s] ? cur[PW'((j + (1 << s)) % DEPTH)] : cur[j];
            end
            cur = nxt;
        end
    end

    // Pack the first WIN_BYTES rotated bytes, head at MSB, masked by count.
    always_comb begin
        win_o = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            if (WNW'(i) < valid_i) begin
                win_o[BYTE_W*(WIN_BYTES-i)-1 -: BYTE_W] = cur[i];
            end
        end
    end

endmodule

// File: rtl/decode_byte_queue.sv
// Instruction byte queue between fetch and decode stage 0.
// Circular byte store with head/tail/count and the PC of the window head.
module decode_byte_queue
    import decode_byte_queue_pkg::*;
#(
    parameter int IADDRW      = 32,
    parameter int FETCH_BYTES = 16,
    parameter int WIN_BYTES   = 16,
    parameter int DEPTH       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic [IADDRW-1:0] flush_pc_i,
    decode_byte_queue_if.slave q_if,
    output logic              err_overread_o
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int FNW = $clog2(FETCH_BYTES) + 1;
    localparam int WNW = $clog2(WIN_BYTES) + 1;

    localparam logic [CW-1:0] READY_LIM = CW'(DEPTH - FETCH_BYTES);
    localparam logic [CW-1:0] WIN_C     = CW'(WIN_BYTES);

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [IADDRW-1:0] pc_q, pc_d;
    logic              err_q, err_d;
    byte_t             mem_q [DEPTH];

    logic              push, pop, pop_ok;
    logic [FNW-1:0]    push_n;
    logic [WNW-1:0]    pop_n, valid_n;

    assign q_if.f_ready       = count_q <= READY_LIM;
    assign valid_n            = (count_q >= WIN_C) ? WNW'(WIN_BYTES) : WNW'(count_q);
    assign q_if.w_valid_bytes = valid_n;
    assign q_if.w_pc          = pc_q;
    assign err_overread_o     = err_q;

    assign pop_ok = q_if.d_bytes_read <= valid_n;
    assign push   = q_if.f_valid & q_if.f_ready & ~flush_i;
    assign pop    = q_if.d_consume & pop_ok & ~flush_i;
    assign push_n = push ? q_if.f_nbytes : '0;
    assign pop_n  = pop ? q_if.d_bytes_read : '0;

    // Next pointers/count/pc; flush rewinds everything and drops this cycle's traffic.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pc_d    = pc_q;
        err_d   = 1'b0;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = flush_pc_i;
        end else begin
            head_d  = head_q + PW'(pop_n);
            tail_d  = tail_q + PW'(push_n);
            count_d = count_q + CW'(push_n) - CW'(pop_n);
            pc_d    = pc_q + IADDRW'(pop_n);
            err_d   = q_if.d_consume & ~pop_ok;
        end
    end

    // Pointer, count, pc and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    // Byte store: line byte k lands at tail+k; contents never cleared.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            for (int k = 0; k < FETCH_BYTES; k++) begin
                if (FNW'(k) < q_if.f_nbytes) begin
                    mem_q[tail_q + PW'(k)] <= q_if.f_bytes[BYTE_W*(FETCH_BYTES-k)-1 -: BYTE_W];
                end
            end
        end
    end

    byte_rotator #(
        .DEPTH     (DEPTH),
        .WIN_BYTES (WIN_BYTES)
    ) u_rot (
        .data_i  (mem_q),
        .head_i  (head_q),
        .valid_i (valid_n),
        .win_o   (q_if.w_bytes)
    );

endmodule

// File: tb/tb_decode_byte_queue.sv
// Directed and random stimulus for decode_byte_queue against a
// byte-queue reference model (SV queue of bytes plus a PC).
module tb_decode_byte_queue;

    localparam int FB  = 16;
    localparam int WIN = 16;
    localparam int DEP = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic        err;

    decode_byte_queue_if #(.IADDRW(32), .FETCH_BYTES(FB), .WIN_BYTES(WIN)) qif ();

    decode_byte_queue #(
        .IADDRW(32), .FETCH_BYTES(FB), .WIN_BYTES(WIN), .DEPTH(DEP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush),
        .flush_pc_i     (flush_pc),
        .q_if           (qif.slave),
        .err_overread_o (err)
    );

    always #5 clk = ~clk;

    logic [7:0]  mq [$];
    logic [31:0] mpc;
    logic        merr;
    int          n_cmp;
    int          n_bad;

    task automatic model_update();
        int sz;
        int wv;
        int rd;
        bit rdy;
        bit ok;
        if (reset) begin
            mq.delete();
            mpc  = 32'h0;
            merr = 1'b0;
        end else if (flush) begin
            mq.delete();
            mpc  = flush_pc;
            merr = 1'b0;
        end else begin
            sz   = mq.size();
            rdy  = (DEP - sz) >= FB;
            wv   = (sz < WIN) ? sz : WIN;
            rd   = int'(qif.d_bytes_read);
            ok   = rd <= wv;
            merr = qif.d_consume && !ok;
            if (qif.d_consume && ok) begin
                for (int i = 0; i < rd; i++) void'(mq.pop_front());
                mpc = mpc + 32'(rd);
            end
            if (qif.f_valid && rdy) begin
                for (int k = 0; k < int'(qif.f_nbytes); k++)
                    mq.push_back(qif.f_bytes[8*(FB-k)-1 -: 8]);
            end
        end
    endtask

    task automatic check_all(string tag);
        int           sz;
        logic [4:0]   e_wv;
        logic [127:0] e_wb;
        logic         e_rdy;
        sz    = mq.size();
        e_wv  = 5'((sz < WIN) ? sz : WIN);
        e_rdy = (DEP - sz) >= FB;
        e_wb  = '0;
        for (int i = 0; i < WIN; i++)
            if (i < sz) e_wb[8*(WIN-i)-1 -: 8] = mq[i];
        n_cmp++;
        assert (qif.w_valid_bytes === e_wv) else begin
            n_bad++;
            $error("FAIL %s w_valid_bytes got %0d want %0d", tag, qif.w_valid_bytes, e_wv);
        end
        n_cmp++;
        assert (qif.w_bytes === e_wb) else begin
            n_bad++;
            $error("FAIL %s w_bytes got %h want %h", tag, qif.w_bytes, e_wb);
        end
        n_cmp++;
        assert (qif.w_pc === mpc) else begin
            n_bad++;
            $error("FAIL %s w_pc got %h want %h", tag, qif.w_pc, mpc);
        end
        n_cmp++;
        assert (qif.f_ready === e_rdy) else begin
            n_bad++;
            $error("FAIL %s f_ready got %b want %b", tag, qif.f_ready, e_rdy);
        end
        n_cmp++;
        assert (err === merr) else begin
            n_bad++;
            $error("FAIL %s err_overread got %b want %b", tag, err, merr);
        end
    endtask

    task automatic drive(bit fv, int n, logic [7:0] base, bit dc, int rd);
        qif.f_valid      = fv;
        qif.f_nbytes     = 5'(n);
        for (int k = 0; k < FB; k++)
            qif.f_bytes[8*(FB-k)-1 -: 8] = base + 8'(k);
        qif.d_consume    = dc;
        qif.d_bytes_read = 5'(rd);
    endtask

    task automatic step(string tag);
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int rd;
        int sz;
        n_cmp    = 0;
        n_bad    = 0;
        mpc      = 32'h0;
        merr     = 1'b0;
        flush    = 1'b0;
        flush_pc = 32'h0;
        reset    = 1'b1;
        drive(0, 0, 8'h00, 0, 0);
        step("reset");
        reset = 1'b0;

        drive(1, 16, 8'h00, 0, 0);   step("push16");
        drive(1, 16, 8'h10, 0, 0);   step("fill32");
        drive(1, 16, 8'h20, 0, 0);   step("held_full");
        drive(1, 16, 8'h20, 1, 5);   step("consume5");
        drive(1, 16, 8'h20, 1, 11);  step("consume11");
        drive(1, 16, 8'h20, 0, 0);   step("accept_held");
        drive(0, 0, 8'h00, 0, 0);    step("idle");

        flush = 1'b1; flush_pc = 32'h0;
        step("flush0");
        flush = 1'b0;
        drive(1, 16, 8'h40, 0, 0);   step("w_fill_a");
        drive(1, 16, 8'h50, 0, 0);   step("w_fill_b");
        drive(0, 0, 8'h00, 1, 16);   step("w_pop16");
        drive(0, 0, 8'h00, 1, 12);   step("w_pop12");
        drive(1, 4, 8'hA0, 0, 0);    step("wrap8");
        drive(0, 0, 8'h00, 1, 6);    step("wrap_pop6");

        drive(1, 8, 8'hC0, 0, 0);    step("count10");
        drive(1, 7, 8'hD0, 1, 3);    step("push_pop");

        flush = 1'b1; flush_pc = 32'h0;
        drive(0, 0, 8'h00, 0, 0);    step("flush_b");
        flush = 1'b0;
        drive(1, 4, 8'h60, 0, 0);    step("count4");
        drive(0, 0, 8'h00, 1, 6);    step("overread");
        drive(0, 0, 8'h00, 1, 0);    step("err_clear");
        drive(0, 0, 8'h00, 1, 4);    step("drain");
        drive(0, 0, 8'h00, 1, 1);    step("empty_over");
        drive(0, 0, 8'h00, 1, 0);    step("empty_zero");

        drive(1, 16, 8'h70, 0, 0);   step("pre_flush");
        flush = 1'b1; flush_pc = 32'h0000_1000;
        drive(1, 16, 8'h80, 1, 4);   step("flush_pc");
        flush = 1'b0;
        drive(1, 0, 8'h00, 0, 0);    step("push_n0");
        reset = 1'b1; flush = 1'b1; flush_pc = 32'h0000_2000;
        drive(0, 0, 8'h00, 0, 0);    step("reset_flush");
        reset = 1'b0; flush = 1'b0;

        for (int c = 0; c < 600; c++) begin
            sz = mq.size();
            if ($urandom_range(0, 9) == 0) rd = int'($urandom_range(0, WIN));
            else rd = int'($urandom_range(0, (sz < WIN) ? sz : WIN));
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, FB)),
                  8'($urandom), bit'($urandom_range(0, 1)), rd);
            for (int k = 0; k < FB; k++) qif.f_bytes[8*k +: 8] = 8'($urandom);
            flush    = ($urandom_range(0, 39) == 0);
            flush_pc = $urandom;
            reset    = ($urandom_range(0, 149) == 0);
            step("random");
        end
        reset = 1'b0;
        flush = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
